// File: rtl/alu_arbiter_if.sv
// Bus bundle for alu_arbiter: two request ports, one response port, the
// operand/result path to the shared ALU, and the debug status outputs.
interface alu_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_instruction;
  logic [WIDTH-1:0] req0_regA;
  logic [WIDTH-1:0] req0_regB;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_instruction;
  logic [WIDTH-1:0] req1_regA;
  logic [WIDTH-1:0] req1_regB;
  logic             resp_valid;
  logic             resp_id;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_result;
  logic [2:0]       resp_flags;
  logic [WIDTH-1:0] alu_instruction;
  logic [WIDTH-1:0] alu_regA;
  logic [WIDTH-1:0] alu_regB;
  logic [WIDTH-1:0] alu_result;
  logic [2:0]       alu_flags;
  logic             busy;
  logic [CNT_W-1:0] op_count;
  logic [CNT_W-1:0] ovf_count;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_instruction, req0_regA, req0_regB,
    input  req1_valid, req1_instruction, req1_regA, req1_regB,
    input  resp_ready, alu_result, alu_flags,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, resp_result, resp_flags,
    output alu_instruction, alu_regA, alu_regB,
    output busy, op_count, ovf_count
  );

  // Requesters / consumer / ALU side
  modport master (
    output req0_valid, req0_instruction, req0_regA, req0_regB,
    output req1_valid, req1_instruction, req1_regA, req1_regB,
    output resp_ready, alu_result, alu_flags,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, resp_result, resp_flags,
    input  alu_instruction, alu_regA, alu_regB,
    input  busy, op_count, ovf_count
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Operands are registered in front of the ALU and results behind it, so the
// ALU path is register-to-register. One op in flight at a time:
// IDLE (accept) -> EXEC (ALU evaluates) -> RESP (wait for consumer).
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic             prio;
  logic             owner;
  logic [WIDTH-1:0] op_instr;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             rsp_vld;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_res;
  logic [2:0]       rsp_flg;
  logic [CNT_W-1:0] n_ops;
  logic [CNT_W-1:0] n_ovf;

  logic             grant_vld;
  logic             grant_id;

  // Grant selection: a lone requester wins outright, a tie goes to prio
  always_comb begin
    grant_vld = bus.req0_valid | bus.req1_valid;
    grant_id  = (bus.req0_valid & bus.req1_valid) ? prio : bus.req1_valid;
  end

  assign bus.req0_ready = (state == IDLE) & grant_vld & ~grant_id;
  assign bus.req1_ready = (state == IDLE) & grant_vld &  grant_id;
  assign bus.busy       = (state != IDLE);

  assign bus.alu_instruction = op_instr;
  assign bus.alu_regA        = op_a;
  assign bus.alu_regB        = op_b;
  assign bus.resp_valid      = rsp_vld;
  assign bus.resp_id         = rsp_id;
  assign bus.resp_result     = rsp_res;
  assign bus.resp_flags      = rsp_flg;
  assign bus.op_count        = n_ops;
  assign bus.ovf_count       = n_ovf;

  // Control FSM with operand, response and debug-counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      prio     <= 1'b0;
      owner    <= 1'b0;
      op_instr <= '0;
      op_a     <= '0;
      op_b     <= '0;
      rsp_vld  <= 1'b0;
      rsp_id   <= 1'b0;
      rsp_res  <= '0;
      rsp_flg  <= '0;
      n_ops    <= '0;
      n_ovf    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_vld) begin
            op_instr <= grant_id ? bus.req1_instruction : bus.req0_instruction;
            op_a     <= grant_id ? bus.req1_regA        : bus.req0_regA;
            op_b     <= grant_id ? bus.req1_regB        : bus.req0_regB;
            owner    <= grant_id;
            state    <= EXEC;
          end
        end
        EXEC: begin
          rsp_res <= bus.alu_result;
          rsp_flg <= bus.alu_flags;
          rsp_id  <= owner;
          rsp_vld <= 1'b1;
          state   <= RESP;
        end
        RESP: begin
          // Response regs stay untouched until the consumer takes them
          if (bus.resp_ready) begin
            rsp_vld <= 1'b0;
            n_ops   <= n_ops + CNT_W'(1);
            if (rsp_flg[2]) n_ovf <= n_ovf + CNT_W'(1);
            prio    <= ~owner;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: single-op vector table plus hand-written
// sequences for arbitration, response backpressure and mid-flight reset.
// A small MIPS ALU model stands in for the shared ALU.
module tb_alu_arbiter;

  localparam int WIDTH = 32;
  localparam int CNT_W = 16;

  localparam logic [31:0] I_ADD  = 32'h0001_4020;
  localparam logic [31:0] I_SUB  = 32'h0001_4022;
  localparam logic [31:0] I_SUBU = 32'h0001_4023;
  localparam logic [31:0] I_XOR  = 32'h0001_4026;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_arbiter_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  alu_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference MIPS ALU (R-type funct decode), flags {ovf, neg, zero}
  always_comb begin
    logic [31:0] a, b, r;
    logic        ovf;
    a = bus.alu_regA;
    b = bus.alu_regB;
    r = '0;
    ovf = 1'b0;
    case (bus.alu_instruction[5:0])
      6'h20: begin r = a + b; ovf = (a[31] == b[31]) && (r[31] != a[31]); end
      6'h21: r = a + b;
      6'h22: begin r = a - b; ovf = (a[31] != b[31]) && (r[31] != a[31]); end
      6'h23: r = a - b;
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h26: r = a ^ b;
      default: r = '0;
    endcase
    bus.alu_result = r;
    bus.alu_flags  = {ovf, r[31], (r == 32'h0)};
  end

  typedef struct {
    logic        id;
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [2:0]  flg;
  } vec_t;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int exp_ops  = 0;
  int exp_ovf  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_instruction = '0; bus.req0_regA = '0; bus.req0_regB = '0;
    bus.req1_valid = 1'b0; bus.req1_instruction = '0; bus.req1_regA = '0; bus.req1_regB = '0;
  endtask

  task automatic drive(input logic id, input logic [31:0] instr, input logic [31:0] a,
                       input logic [31:0] b);
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_instruction = instr; bus.req1_regA = a; bus.req1_regB = b;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_instruction = instr; bus.req0_regA = a; bus.req0_regB = b;
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) step();
    rst = 1'b0;
    exp_ops = 0;
    exp_ovf = 0;
  endtask

  // One op through a single requester with resp_ready held high
  task automatic do_op(input vec_t v);
    bus.resp_ready = 1'b1;
    drive(v.id, v.instr, v.a, v.b);
    #1;
    chk("op_ready_granted", v.id ? bus.req1_ready : bus.req0_ready, 1);
    chk("op_ready_other",   v.id ? bus.req0_ready : bus.req1_ready, 0);
    step();
    idle_inputs();
    chk("exec_busy", bus.busy, 1);
    chk("exec_resp_valid", bus.resp_valid, 0);
    chk("exec_alu_instr", bus.alu_instruction, v.instr);
    chk("exec_alu_a", bus.alu_regA, v.a);
    chk("exec_alu_b", bus.alu_regB, v.b);
    step();
    chk("resp_valid", bus.resp_valid, 1);
    chk("resp_id", bus.resp_id, v.id);
    chk("resp_result", bus.resp_result, v.res);
    chk("resp_flags", bus.resp_flags, v.flg);
    step();
    exp_ops++;
    if (v.flg[2]) exp_ovf++;
    chk("done_resp_valid", bus.resp_valid, 0);
    chk("done_busy", bus.busy, 0);
    chk("op_count", bus.op_count, exp_ops);
    chk("ovf_count", bus.ovf_count, exp_ovf);
    chk("hold_alu_a", bus.alu_regA, v.a);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b0, I_ADD,  32'd4,          32'd5,          32'd9,          3'b000};
    vecs[1] = '{1'b1, I_ADD,  32'd2147483640, 32'd2147483641, 32'hFFFF_FFF1,  3'b110};
    vecs[2] = '{1'b0, I_SUB,  32'd99,         32'd25,         32'd74,         3'b000};
    vecs[3] = '{1'b1, I_XOR,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0,          3'b001};
    vecs[4] = '{1'b0, I_SUBU, 32'd50,         32'd120,        32'hFFFF_FFBA,  3'b010};
    vecs[5] = '{1'b1, I_SUB,  32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  3'b100};

    idle_inputs();
    bus.resp_ready = 1'b0;
    #1;
    do_reset(2);

    // Reset state
    chk("rst_busy", bus.busy, 0);
    chk("rst_ready0", bus.req0_ready, 0);
    chk("rst_ready1", bus.req1_ready, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_id", bus.resp_id, 0);
    chk("rst_resp_result", bus.resp_result, 0);
    chk("rst_resp_flags", bus.resp_flags, 0);
    chk("rst_alu_instr", bus.alu_instruction, 0);
    chk("rst_alu_a", bus.alu_regA, 0);
    chk("rst_alu_b", bus.alu_regB, 0);
    chk("rst_op_count", bus.op_count, 0);
    chk("rst_ovf_count", bus.ovf_count, 0);

    // Idle cycles with no request: no grant, stays idle
    step();
    chk("idle_busy", bus.busy, 0);

    foreach (vecs[i]) do_op(vecs[i]);

    // Both requesters valid continuously: grants alternate starting at 0
    do_reset(1);
    bus.resp_ready = 1'b1;
    drive(1'b0, I_ADD, 32'd2147483640, 32'd2147483641);
    drive(1'b1, I_SUB, 32'd99, 32'd25);
    #1;
    for (int i = 0; i < 4; i++) begin
      logic g;
      g = i[0];
      chk("rr_ready0", bus.req0_ready, !g);
      chk("rr_ready1", bus.req1_ready, g);
      step();
      chk("rr_exec_ready0", bus.req0_ready, 0);
      chk("rr_exec_ready1", bus.req1_ready, 0);
      step();
      chk("rr_resp_id", bus.resp_id, g);
      chk("rr_resp_result", bus.resp_result, g ? 32'd74 : 32'hFFFF_FFF1);
      chk("rr_resp_flags", bus.resp_flags, g ? 3'b000 : 3'b110);
      step();
      exp_ops++;
      if (!g) exp_ovf++;
      chk("rr_op_count", bus.op_count, exp_ops);
      chk("rr_ovf_count", bus.ovf_count, exp_ovf);
    end
    idle_inputs();
    step();

    // Response backpressure: everything frozen while resp_ready is low
    bus.resp_ready = 1'b0;
    drive(1'b1, I_XOR, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step();
    idle_inputs();
    step();
    drive(1'b0, I_ADD, 32'd1, 32'd1);
    drive(1'b1, I_ADD, 32'd2, 32'd2);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_resp_valid", bus.resp_valid, 1);
      chk("bp_resp_id", bus.resp_id, 1);
      chk("bp_resp_result", bus.resp_result, 32'h0);
      chk("bp_resp_flags", bus.resp_flags, 3'b001);
      chk("bp_ready0", bus.req0_ready, 0);
      chk("bp_ready1", bus.req1_ready, 0);
      chk("bp_op_count", bus.op_count, exp_ops);
      step();
    end
    idle_inputs();
    bus.resp_ready = 1'b1;
    step();
    exp_ops++;
    chk("bp_release_op_count", bus.op_count, exp_ops);
    chk("bp_release_valid", bus.resp_valid, 0);

    // Reset asserted while an op is in EXEC: op dropped, state cleared
    drive(1'b0, I_ADD, 32'd7, 32'd8);
    step();
    idle_inputs();
    chk("mid_busy_pre", bus.busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_ops = 0;
    exp_ovf = 0;
    chk("mid_busy", bus.busy, 0);
    chk("mid_resp_valid", bus.resp_valid, 0);
    chk("mid_resp_result", bus.resp_result, 0);
    chk("mid_op_count", bus.op_count, 0);
    chk("mid_ovf_count", bus.ovf_count, 0);
    step();
    chk("mid_still_idle", bus.busy, 0);
    do_op(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
